// File: rtl/dmem_port.sv
// MEM-stage data-memory responder: one cache handshake per load/store, stalls until response.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip the cache and raise trap.
module dmem_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] mar,
  input  logic [31:0] mem_wdata,
  input  logic        load,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  output logic        stall,
  output logic [31:0] load_data,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic        trap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_data_q, load_data_d;
  logic [3:0]  rmask_q, rmask_d;
  logic [3:0]  wmask_q, wmask_d;

  logic        req;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext_data;

  assign req = mem_read | mem_write;

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = mem_wdata;
    case (funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << mar[1:0];
        req_wdata = mem_wdata << {mar[1:0], 3'b000};
      end
      2'b01: begin
        req_be    = 4'b0011 << {mar[1], 1'b0};
        req_wdata = mem_wdata << {mar[1], 4'b0000};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = mem_wdata;
      end
    endcase
  end

  // Lane extraction uses the offset captured with the request, not the live mar.
  always_comb begin
    byte_sh  = dmem_rdata >> {off_q, 3'b000};
    half_sh  = dmem_rdata >> {off_q[1], 4'b0000};
    rd_byte  = byte_sh[7:0];
    rd_half  = half_sh[15:0];
    ext_data = dmem_rdata;
    case (f3_q)
      3'b000:  ext_data = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ext_data = {24'h000000, rd_byte};
      3'b001:  ext_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  ext_data = {16'h0000, rd_half};
      default: ext_data = dmem_rdata;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  logic misaligned;
  assign misaligned = ((funct3[1:0] == 2'b01) && mar[0]) ||
                      (funct3[1] && (mar[1:0] != 2'b00));
`endif

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    f3_d        = f3_q;
    off_d       = off_q;
    load_data_d = load_data_q;
    rmask_d     = rmask_q;
    wmask_d     = wmask_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap_d      = trap_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = mar[31:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          f3_d    = funct3;
          off_d   = mar[1:0];
          // A simultaneous read and write is treated as a write.
          wr_d    = mem_write;
          rd_d    = ~mem_write;
          state_d = BUSY;
`ifdef DMEM_MISALIGN_TRAP_EN
          if (misaligned) begin
            rd_d        = 1'b0;
            wr_d        = 1'b0;
            trap_d      = 1'b1;
            load_data_d = 32'h0;
            rmask_d     = 4'h0;
            wmask_d     = 4'h0;
            state_d     = DONE;
          end
`endif
        end
      end
      BUSY: begin
        if (dmem_resp) begin
          if (wr_q) begin
            rmask_d = 4'h0;
            wmask_d = be_q;
          end else begin
            load_data_d = ext_data;
            rmask_d     = be_q;
            wmask_d     = 4'h0;
          end
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (load) begin
          state_d = IDLE;
`ifdef DMEM_MISALIGN_TRAP_EN
          trap_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      load_data_q <= '0;
      rmask_q     <= '0;
      wmask_q     <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
      rmask_q     <= rmask_d;
      wmask_q     <= wmask_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      trap_q      <= trap_d;
`endif
    end
  end

  assign stall            = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign dmem_read        = rd_q;
  assign dmem_write       = wr_q;
  assign dmem_address     = {addr_q, 2'b00};
  assign dmem_wdata       = wdata_q;
  assign dmem_byte_enable = be_q;
  assign load_data        = load_data_q;
  assign rmask            = rmask_q;
  assign wmask            = wmask_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap             = trap_q;
`else
  assign trap             = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_port.sv
// Randomized self-checking bench for dmem_port against an arithmetic access model.
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, load, dmem_resp;
  logic [2:0]  funct3;
  logic [31:0] mar, mem_wdata, dmem_rdata;
  logic        dmem_read, dmem_write, stall, trap;
  logic [31:0] dmem_address, dmem_wdata, load_data;
  logic [3:0]  dmem_byte_enable, rmask, wmask;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_ld = 32'h0;

  always #5 clk = ~clk;

  dmem_port dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .mar(mar), .mem_wdata(mem_wdata), .load(load),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .stall(stall), .load_data(load_data),
    .rmask(rmask), .wmask(wmask), .trap(trap)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_txn(input bit is_wr, input bit is_rd, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int waits, input int hold);
    int unsigned off, b, h;
    logic [3:0]  be;
    logic [31:0] wexp, lexp;
    bit          mis;
    int          strobe_cnt;
    off = addr[1:0];
    case (f3[1:0])
      2'b00:   begin be = 4'(1 << off);           wexp = wd << (8 * off); end
      2'b01:   begin be = 4'(3 << (2 * (off / 2))); wexp = wd << (16 * (off / 2)); end
      default: begin be = 4'hF;                    wexp = wd; end
    endcase
    b = (rdat >> (8 * off)) % 256;
    h = (rdat >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    lexp = (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    lexp = b;
      3'd1:    lexp = (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    lexp = h;
      default: lexp = rdat;
    endcase
    mis = (f3[1:0] == 2'b01 && (off % 2) == 1) || (f3[1] && off != 0);

    @(negedge clk);
    mem_read = is_rd; mem_write = is_wr; funct3 = f3; mar = addr; mem_wdata = wd; load = 1'b0;
    #1;
    chk("stall_T", stall, 1);
    chk("strobe_T", {dmem_read, dmem_write}, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (mis) begin
      @(negedge clk); #1;
      exp_ld = 32'h0;
      chk("trap_set", trap, 1);
      chk("trap_stall", stall, 0);
      chk("trap_strobe", {dmem_read, dmem_write}, 0);
      chk("trap_rmask", rmask, 0);
      chk("trap_wmask", wmask, 0);
      chk("trap_ld", load_data, 0);
    end else
`endif
    begin
      strobe_cnt = 0;
      for (int i = 0; i <= waits; i++) begin
        @(negedge clk);
        dmem_rdata = (i == waits) ? rdat : $urandom;
        dmem_resp  = (i == waits);
        #1;
        if (dmem_read | dmem_write) strobe_cnt++;
        chk("busy_stall", stall, 1);
        chk("busy_strobe", {dmem_read, dmem_write}, is_wr ? 2'b01 : 2'b10);
        chk("busy_addr", dmem_address, {addr[31:2], 2'b00});
        chk("busy_be", dmem_byte_enable, be);
        chk("busy_wdata", dmem_wdata, wexp);
      end
      chk("strobe_cycles", strobe_cnt, waits + 1);
      @(negedge clk);
      dmem_resp = 1'b0;
      #1;
      if (!is_wr) exp_ld = lexp;
      chk("done_stall", stall, 0);
      chk("done_strobe", {dmem_read, dmem_write}, 0);
      chk("done_ld", load_data, exp_ld);
      chk("done_rmask", rmask, is_wr ? 4'h0 : be);
      chk("done_wmask", wmask, is_wr ? be : 4'h0);
      chk("done_trap", trap, 0);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      dmem_resp  = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #1;
      chk("hold_stall", stall, 0);
      chk("hold_strobe", {dmem_read, dmem_write}, 0);
      chk("hold_ld", load_data, exp_ld);
    end
    @(negedge clk);
    dmem_resp = 1'b0; load = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    load = 1'b0;
    #1;
    chk("idle_stall", stall, 0);
    chk("idle_trap", trap, 0);
    chk("idle_strobe", {dmem_read, dmem_write}, 0);
  endtask

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; load = 0; dmem_resp = 0;
    funct3 = 0; mar = 0; mem_wdata = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_strobe", {dmem_read, dmem_write}, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_addr", dmem_address, 0);
    chk("rst_masks", {rmask, wmask}, 0);
    chk("rst_trap", trap, 0);
    @(negedge clk); rst = 1'b0;

    do_txn(0, 1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    chk("lw_value", load_data, 32'hDEADBEEF);
    do_txn(0, 1, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 0);
    chk("lb_value", load_data, 32'hFFFFFF80);
    do_txn(0, 1, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0);
    chk("lbu_value", load_data, 32'h00000080);
    do_txn(1, 0, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 3, 0);
    do_txn(0, 1, 3'b010, 32'h300, 32'h0, 32'h12345678, 0, 5);
    do_txn(1, 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 1, 1);

    // response arriving while idle must not disturb results
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 32'h55AA55AA;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk("idle_resp_ld", load_data, exp_ld);
    chk("idle_resp_strobe", {dmem_read, dmem_write}, 0);

    // reset in the middle of a busy read, then a late response
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; mar = 32'h500;
    @(negedge clk); #1;
    chk("pre_rst_read", dmem_read, 1);
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk); #1;
    chk("midrst_strobe", {dmem_read, dmem_write}, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_ld", load_data, 0);
    rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk("late_resp_ld", load_data, 0);
    chk("late_resp_rmask", rmask, 0);
    chk("late_resp_stall", stall, 0);
    exp_ld = 32'h0;

    do_txn(0, 1, 3'b010, 32'h102, 32'h0, 32'hA5A5_0F0F, 0, 0);
    do_txn(0, 1, 3'b001, 32'h103, 32'h0, 32'h8001_7F02, 0, 0);

    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = $urandom_range(0, 2);
      do_txn(sel != 0, sel != 1, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_port.md
# dmem_port

Data-memory responder for the MEM stage. It consumes the registered `mem_read`, `mem_write`, `mar_out`, `mem_wdata` and `funct3` outputs of the EX/MEM pipeline register and runs one handshake per access on the data-cache bus: word-aligned address, byte enables and lane-shifted write data. It stalls the pipeline until `dmem_resp` and returns aligned, sign- or zero-extended load data plus monitor masks to MEM/WB.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset
- `mem_read`  in  1  load request from EX/MEM; already gated by commit
- `mem_write`  in  1  store request from EX/MEM; already gated by commit
- `funct3`  in  3  access size and signedness
- `mar`  in  32  byte address
- `mem_wdata`  in  32  unshifted store data (rs2)
- `load`  in  1  pipeline advance; MEM/WB captures results on this cycle
- `dmem_resp`  in  1  cache response, single-cycle pulse
- `dmem_rdata`  in  32  cache read word, valid with `dmem_resp`
- `dmem_read`  out  1  cache read strobe
- `dmem_write`  out  1  cache write strobe
- `dmem_address`  out  32  `{mar[31:2],2'b00}`
- `dmem_wdata`  out  32  lane-shifted store data
- `dmem_byte_enable`  out  4  byte lanes
- `stall`  out  1  holds all pipeline registers
- `load_data`  out  32  extended load result
- `rmask` / `wmask`  out  4 each  monitor masks of the completed access
- `trap`  out  1  misaligned access (only with `DMEM_MISALIGN_TRAP_EN`)

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request:
  - `stall`=0.
- IDLE, `mem_read|mem_write`:
  - `stall`=1 combinationally.
  - On the clock edge, latch address, enables, shifted data and funct3, then go to BUSY.
- BUSY:
  - `dmem_read` or `dmem_write` is held high with stable address, data and enables.
  - `stall`=1.
  - On `dmem_resp`, register `load_data`, `rmask`/`wmask`, drop the strobes, and go to DONE.
- DONE:
  - `stall`=0; results are held.
  - `load`=1 moves to IDLE.
  - `load`=0 keeps DONE (upstream stall), and the same request is not reissued.
- Byte enables by funct3[1:0]:
  - 00 (byte): `4'b0001<<mar[1:0]`.
  - 01 (half): `4'b0011<<{mar[1],1'b0}`.
  - 10 and others: `4'b1111`.
- `dmem_wdata` = `mem_wdata << (8*mar[1:0])` for byte, `<<16*mar[1]` for half, unshifted for word.
- Load extraction:
  - lb/lbu (000/100): select byte `mar[1:0]`, then sign- or zero-extend.
  - lh/lhu (001/101): select half `mar[1]`, then extend.
  - lw and others: full word.
- `rmask` = enables for loads, else 0. `wmask` = enables for stores, else 0.
- `mem_read` and `mem_write` both high: treat as a write.
- `dmem_resp` outside BUSY is ignored.

## Timing
- Reset: state IDLE; all outputs 0 (`stall` follows combinational IDLE rule). An outstanding cache response after reset is ignored.
- Minimum load/store occupancy is 3 cycles:
  - T: request seen, `stall`=1.
  - T+1: BUSY, strobe high; `dmem_resp` is allowed this cycle.
  - T+2: DONE, `stall`=0, `load_data` valid.
- Each extra cache wait cycle adds one BUSY cycle.
- Back-to-back accesses: a request present in the cycle after DONE+`load` starts a new transaction at that cycle (IDLE rule).
- Strobes are registered; they never go high in the same cycle as the request is first seen.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned means half with `mar[0]`=1, or word with `mar[1:0]`≠0.
  - A misaligned request in IDLE issues no cache strobe and goes directly to DONE next cycle.
  - In DONE: `trap`=1, `rmask`=`wmask`=0, `load_data`=0.
  - `trap` clears on leaving DONE.
- Undefined:
  - `trap` is tied 0.
  - Misaligned accesses are issued using the lane rules above. Low address bits beyond the lane selection are ignored, e.g. lh at offset 3 reads bytes [3:2].

## Test plan
- lw at `mar`=0x100, `dmem_resp` at T+1 with rdata 0xDEADBEEF:
  - `dmem_address`=0x100, enables 1111.
  - `stall` high for T..T+1.
  - T+2 `load_data`=0xDEADBEEF, `rmask`=1111.
- lb at 0x103 with rdata 0x80112233 -> `load_data`=0xFFFFFF80. lbu at 0x103 -> 0x00000080.
- sh at 0x202 with rs2=0x0000ABCD and 3 wait cycles:
  - `dmem_address`=0x200, enables 1100, `dmem_wdata`=0xABCD0000.
  - `dmem_write` high for 4 cycles; `wmask`=1100.
- DONE held with `load`=0 for 5 cycles:
  - no second strobe.
  - `load_data` stable.
  - then a `load` pulse returns the block to IDLE.
- `rst` asserted mid-BUSY, then a late `dmem_resp`:
  - strobes drop next cycle.
  - the response is ignored.
  - state is IDLE, `load_data`=0.
- With `DMEM_MISALIGN_TRAP_EN`, lw at 0x102:
  - no `dmem_read`.
  - the next cycle has `trap`=1, `stall`=0, masks 0.
- Without `DMEM_MISALIGN_TRAP_EN`, the same access reads 0x100 with `trap`=0.
